ovr_chan_ctrl: RTL and testbench
================================

# ovr_chan_ctrl

Multi-channel override controller: the parametrised, synthesizable successor to ad-hoc procedural `assign`/`deassign` overrides. Each channel normally passes a functional value through a register. A command interface can force a channel to a constant, either indefinitely or for a programmed number of cycles, and release it again. It sits between functional logic and consumers that need debug or bring-up overrides, and reports override status, output changes and expiries.

## Interface
- `NUM_CH`, default 4: number of channels (≥1)
- `WIDTH`, default 8: bits per channel
- `CNT_W`, default 16: hold-counter width
- `RST_VAL`, default `'0`: `WIDTH`-bit reset value of every channel output
- `clk` in 1: single clock; all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `func_i` in `NUM_CH*WIDTH`: functional values; channel c is `[c*WIDTH +: WIDTH]`
- `cmd_valid_i` in 1: command valid
- `cmd_ready_o` out 1: command ready
- `cmd_op_i` in 2: opcode, one of NOP=0, ASSIGN=1, DEASSIGN=2, DEASSIGN_ALL=3
- `cmd_ch_i` in `$clog2(NUM_CH)` (min 1): target channel
- `cmd_val_i` in `WIDTH`: override value
- `cmd_hold_i` in `CNT_W`: hold cycles; 0 means indefinite
- `out_o` out `NUM_CH*WIDTH`: registered channel outputs
- `ovr_active_o` out `NUM_CH`: channel currently overridden
- `chg_o` out `NUM_CH`: 1-cycle pulse, `out_o` channel value changed at the last edge
- `expire_o` out `NUM_CH`: 1-cycle pulse, timed override auto-released
- `err_o` out 1: 1-cycle pulse, accepted command had `cmd_ch_i >= NUM_CH`

## Operation
- **Per-channel FSM**
  - PASS: output follows `func_i`.
  - HELD: override with no timeout.
  - TIMED: override with a counter running.
- **Acceptance:** a command is accepted on an edge where `cmd_valid_i && cmd_ready_o`. `cmd_ready_o` is 0 during reset and 1 on every cycle after reset deasserts. There is no back-pressure otherwise.
- **ASSIGN**
  - Stores `cmd_val_i`.
  - `cmd_hold_i==0` → HELD. Otherwise → TIMED with counter = `cmd_hold_i`.
  - ASSIGN on an already-overridden channel replaces the value and the mode, and reloads the counter.
- **DEASSIGN:** target → PASS. A no-op if the target is already in PASS.
- **DEASSIGN_ALL:** every channel → PASS. `cmd_ch_i` is ignored.
- **NOP:** accepted with no effect.
- **Invalid channel:** ASSIGN/DEASSIGN with `cmd_ch_i >= NUM_CH` is accepted and ignored, and pulses `err_o`.
- **TIMED countdown:** the counter decrements every cycle. On the edge where the counter equals 1, the channel → PASS and `expire_o[c]` pulses.
- **Output update:** `out_o[c]` is loaded every edge from next-state: override value if next-state ≠ PASS, else `func_i[c]`.
- **Change pulse:** `chg_o[c]` is registered as (new `out_o[c]` ≠ old `out_o[c]`).
- **Simultaneous events**
  - ASSIGN to a TIMED channel on its expiry edge: the command wins, the counter reloads, no `expire_o`.
  - DEASSIGN on the expiry edge: → PASS, no `expire_o`.
- **Arithmetic:** the counter is unsigned `CNT_W` bits and never wraps; a counter of 0 never occurs in TIMED.

## Timing
- **Reset values:** `out_o` = `RST_VAL` in every channel, `ovr_active_o`=0, `chg_o`=0, `expire_o`=0, `err_o`=0, `cmd_ready_o`=0. All FSMs → PASS and all counters → 0.
- **Reset priority:** reset asserted mid-override clears everything on that edge. A command presented during reset is dropped.
- **Pass-through latency:** 1 cycle from `func_i` to `out_o`.
- **Command latency:** a command accepted at edge N is visible on `out_o`/`ovr_active_o` after edge N.
- **Timed window:** a TIMED override accepted at edge N holds the override value for exactly `cmd_hold_i` cycles.
  - It releases at edge N+`cmd_hold_i`; `out_o` shows `func_i` sampled at that edge.
  - `expire_o` is high for the cycle following that edge.
- **Pulse alignment:** `chg_o`, `expire_o` and `err_o` are high for exactly one cycle, aligned with the `out_o` update that caused them.

## Configuration
- **`OVR_TIMER_EN` defined:** TIMED mode, per-channel counters and `expire_o` are built.
- **`OVR_TIMER_EN` undefined:**
  - `cmd_hold_i` is ignored and every ASSIGN → HELD.
  - `expire_o` is tied to 0.
  - No counters are instantiated.
  - Ports are unchanged.

## Structure
- **Package `ovr_pkg`**
  - Enum `ovr_op_e` for the opcodes.
  - Enum `ovr_state_e` for PASS/HELD/TIMED.
  - Opcode width constant.
- **Sub-module `ovr_channel`:** one per channel, generated `NUM_CH` times. It contains the FSM, value register, counter, output register and `chg`/`expire` pulses.
- **Top level:** command decode, channel select, the `DEASSIGN_ALL` broadcast and `err_o`.

## Test plan
- **Reset:** hold `rst` 3 cycles with `RST_VAL=8'hA5` → every channel of `out_o`=A5, all flags 0, `cmd_ready_o`=0. After release, `out_o` tracks `func_i` with 1-cycle latency.
- **Indefinite override:** ASSIGN ch2 val=3C hold=0 → `ovr_active_o[2]`=1 and `out_o` ch2=3C while `func_i` toggles. DEASSIGN ch2 → `out_o` ch2 returns to `func_i` next edge and `chg_o[2]` pulses.
- **Timed expiry:** ASSIGN ch1 val=FF hold=5 at edge N → ch1=FF for 5 cycles, PASS at N+5, `expire_o[1]` high for exactly one cycle.
- **Reload on expiry edge:** ASSIGN ch1 hold=3, then re-ASSIGN ch1 val=11 hold=4 on the expiry edge → no `expire_o`; ch1=11 for 4 more cycles.
- **Invalid channel and broadcast release:** with `NUM_CH=3`, ASSIGN `cmd_ch_i`=3 → `err_o` pulses, no state change. DEASSIGN_ALL with all three channels held → all `ovr_active_o`=0 after one edge.
- **Reset mid-override:** `rst` during a TIMED override with 10 cycles left → PASS immediately, `out_o`=`RST_VAL`, no `expire_o`.
- **Macro off:** with `OVR_TIMER_EN` undefined, ASSIGN ch0 hold=2 → the override persists beyond 100 cycles and `expire_o` stays 0.

Source files
------------

// File: rtl/ovr_chan_ctrl_pkg.sv
// Shared types for the override controller: opcodes, channel FSM states, width helper.
package ovr_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP          = 2'd0,
    OP_ASSIGN       = 2'd1,
    OP_DEASSIGN     = 2'd2,
    OP_DEASSIGN_ALL = 2'd3
  } ovr_op_e;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_HELD  = 2'd1,
    ST_TIMED = 2'd2
  } ovr_state_e;

  // Channel-select width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ovr_chan_ctrl_if.sv
// Command port of the override controller (valid/ready handshake plus payload).
interface ovr_chan_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 16
);
  localparam int CH_W = ovr_pkg::ch_width(NUM_CH);

  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic [ovr_pkg::OP_W-1:0]  cmd_op_i;
  logic [CH_W-1:0]           cmd_ch_i;
  logic [WIDTH-1:0]          cmd_val_i;
  logic [CNT_W-1:0]          cmd_hold_i;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_ch_i, cmd_val_i, cmd_hold_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_ch_i, cmd_val_i, cmd_hold_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/ovr_chan_ctrl_channel.sv
// One override channel: PASS/HELD/TIMED FSM, value register, registered output and pulses.
// Hold counter and expiry exist only when OVR_TIMER_EN is defined.
module ovr_channel
  import ovr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_func,
  input  logic             i_assign,
  input  logic             i_deassign,
  input  logic [WIDTH-1:0] i_val,
  input  logic [CNT_W-1:0] i_hold,
  output logic [WIDTH-1:0] o_out,
  output logic             o_active,
  output logic             o_chg,
  output logic             o_expire
);

  ovr_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_val, w_val_next;
  logic [WIDTH-1:0] r_out, w_out_next;
  logic             r_chg, r_expire, w_expire_next;

`ifdef OVR_TIMER_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_val_next    = r_val;
    w_expire_next = 1'b0;
`ifdef OVR_TIMER_EN
    w_cnt_next    = r_cnt;
`endif
    // A command always beats an expiry landing on the same edge.
    if (i_deassign) begin
      w_state_next = ST_PASS;
`ifdef OVR_TIMER_EN
      w_cnt_next   = '0;
`endif
    end else if (i_assign) begin
      w_val_next = i_val;
`ifdef OVR_TIMER_EN
      if (i_hold == '0) begin
        w_state_next = ST_HELD;
        w_cnt_next   = '0;
      end else begin
        w_state_next = ST_TIMED;
        w_cnt_next   = i_hold;
      end
`else
      w_state_next = ST_HELD;
`endif
    end
`ifdef OVR_TIMER_EN
    else if (r_state == ST_TIMED) begin
      if (r_cnt == CNT_W'(1)) begin
        w_state_next  = ST_PASS;
        w_cnt_next    = '0;
        w_expire_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt - CNT_W'(1);
      end
    end
`endif
    w_out_next = (w_state_next != ST_PASS) ? w_val_next : i_func;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_PASS;
      r_val    <= RST_VAL;
      r_out    <= RST_VAL;
      r_chg    <= 1'b0;
      r_expire <= 1'b0;
`ifdef OVR_TIMER_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_val    <= w_val_next;
      r_out    <= w_out_next;
      r_chg    <= (w_out_next != r_out);
      r_expire <= w_expire_next;
`ifdef OVR_TIMER_EN
      r_cnt    <= w_cnt_next;
`endif
    end
  end

`ifndef OVR_TIMER_EN
  logic w_hold_unused;
  assign w_hold_unused = ^i_hold;
`endif

  assign o_out    = r_out;
  assign o_active = (r_state != ST_PASS);
  assign o_chg    = r_chg;
  assign o_expire = r_expire;

endmodule

// File: rtl/ovr_chan_ctrl.sv
// Multi-channel override controller top: command decode, channel select, broadcast release, err_o.
// Timed overrides and expire_o are built only when OVR_TIMER_EN is defined.
module ovr_chan_ctrl
  import ovr_pkg::*;
#(
  parameter int               NUM_CH  = 4,
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] func_i,
  ovr_chan_ctrl_if.slave          cmd,
  output logic [NUM_CH*WIDTH-1:0] out_o,
  output logic [NUM_CH-1:0]       ovr_active_o,
  output logic [NUM_CH-1:0]       chg_o,
  output logic [NUM_CH-1:0]       expire_o,
  output logic                    err_o
);

  localparam int CH_W = ch_width(NUM_CH);

  logic              r_ready, r_err;
  logic              w_acc, w_ch_bad, w_targeted;
  ovr_op_e           w_op;
  logic [NUM_CH-1:0] w_assign, w_deassign, w_expire;

  assign w_acc      = cmd.cmd_valid_i && r_ready;
  assign w_op       = ovr_op_e'(cmd.cmd_op_i);
  assign w_ch_bad   = {1'b0, cmd.cmd_ch_i} >= (CH_W+1)'(NUM_CH);
  assign w_targeted = (w_op == OP_ASSIGN) || (w_op == OP_DEASSIGN);

  // ready drops with reset and returns one edge after it is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_acc && w_targeted && w_ch_bad;
    end
  end

  assign cmd.cmd_ready_o = r_ready;
  assign err_o           = r_err;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic w_sel;
      assign w_sel          = (cmd.cmd_ch_i == CH_W'(gi));
      assign w_assign[gi]   = w_acc && (w_op == OP_ASSIGN) && w_sel;
      assign w_deassign[gi] = w_acc && (((w_op == OP_DEASSIGN) && w_sel) ||
                                        (w_op == OP_DEASSIGN_ALL));

      ovr_channel #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .RST_VAL (RST_VAL)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .i_func     (func_i[gi*WIDTH +: WIDTH]),
        .i_assign   (w_assign[gi]),
        .i_deassign (w_deassign[gi]),
        .i_val      (cmd.cmd_val_i),
        .i_hold     (cmd.cmd_hold_i),
        .o_out      (out_o[gi*WIDTH +: WIDTH]),
        .o_active   (ovr_active_o[gi]),
        .o_chg      (chg_o[gi]),
        .o_expire   (w_expire[gi])
      );
    end
  endgenerate

`ifdef OVR_TIMER_EN
  assign expire_o = w_expire;
`else
  logic w_expire_unused;
  assign w_expire_unused = |w_expire;
  assign expire_o        = '0;
`endif

endmodule

// File: tb/tb_ovr_chan_ctrl.sv
// Scoreboarded bench for ovr_chan_ctrl (NUM_CH=3, RST_VAL=A5); timed cases only with OVR_TIMER_EN.
module tb_ovr_chan_ctrl;
  import ovr_pkg::*;

  localparam int          NC = 3;
  localparam int          W  = 8;
  localparam int          CW = 16;
  localparam logic [W-1:0] RV = 8'hA5;
`ifdef OVR_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NC*W-1:0] func = '0;
  logic [NC*W-1:0] out;
  logic [NC-1:0]   act, chg, expo;
  logic            err;

  ovr_chan_ctrl_if #(.NUM_CH(NC), .WIDTH(W), .CNT_W(CW)) cmd_if ();

  ovr_chan_ctrl #(
    .NUM_CH (NC),
    .WIDTH  (W),
    .CNT_W  (CW),
    .RST_VAL(RV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .func_i      (func),
    .cmd         (cmd_if),
    .out_o       (out),
    .ovr_active_o(act),
    .chg_o       (chg),
    .expire_o    (expo),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC*W-1:0] out;
    logic [NC-1:0]   act;
    logic [NC-1:0]   chg;
    logic [NC-1:0]   expo;
    logic            err;
    logic            rdy;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           m_st[NC];
  int           m_cnt[NC];
  logic [W-1:0] m_val[NC];
  logic [W-1:0] m_out[NC];
  logic         m_rdy = 1'b0;
  int           cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // Predict the post-edge outputs from the inputs now applied, then step the clock and compare.
  task automatic tick();
    exp_t       e;
    logic       acc;
    int         ch, op, nst;
    logic [W-1:0] nout;
    e = '0;
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        m_st[c]  = 0;
        m_cnt[c] = 0;
        m_out[c] = RV;
      end
      m_rdy = 1'b0;
      e.out = {NC{RV}};
    end else begin
      acc = cmd_if.cmd_valid_i && m_rdy;
      ch  = int'(cmd_if.cmd_ch_i);
      op  = int'(cmd_if.cmd_op_i);
      for (int c = 0; c < NC; c++) begin
        nst = m_st[c];
        if (acc && (op == 3 || (op == 2 && ch == c))) begin
          nst = 0;
        end else if (acc && op == 1 && ch == c) begin
          m_val[c] = cmd_if.cmd_val_i;
          if (TIMER && cmd_if.cmd_hold_i != '0) begin
            nst      = 2;
            m_cnt[c] = int'(cmd_if.cmd_hold_i);
          end else begin
            nst = 1;
          end
        end else if (m_st[c] == 2) begin
          if (m_cnt[c] == 1) begin
            nst        = 0;
            e.expo[c]  = 1'b1;
          end else begin
            m_cnt[c]--;
          end
        end
        nout             = (nst != 0) ? m_val[c] : func[c*W +: W];
        e.chg[c]         = (nout != m_out[c]);
        m_out[c]         = nout;
        m_st[c]          = nst;
        e.out[c*W +: W]  = nout;
        e.act[c]         = (nst != 0);
      end
      e.err = acc && (op == 1 || op == 2) && (ch >= NC);
      e.rdy = 1'b1;
      m_rdy = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check("out_o",        32'(out),  32'(e.out));
    check("ovr_active_o", 32'(act),  32'(e.act));
    check("chg_o",        32'(chg),  32'(e.chg));
    check("expire_o",     32'(expo), 32'(e.expo));
    check("err_o",        32'(err),  32'(e.err));
    check("cmd_ready_o",  32'(cmd_if.cmd_ready_o), 32'(e.rdy));
  endtask

  task automatic send(input int op, input int ch, input logic [W-1:0] val, input int hold);
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_op_i    = 2'(op);
    cmd_if.cmd_ch_i    = 2'(ch);
    cmd_if.cmd_val_i   = val;
    cmd_if.cmd_hold_i  = CW'(hold);
    tick();
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_op_i    = 2'd0;
  endtask

  initial begin
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_op_i    = 2'd0;
    cmd_if.cmd_ch_i    = 2'd0;
    cmd_if.cmd_val_i   = '0;
    cmd_if.cmd_hold_i  = '0;
    #1;

    // Reset for three edges, with a command offered that must be dropped.
    func = 24'h123456;
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_op_i    = 2'd1;
    for (int i = 0; i < 3; i++) tick();
    cmd_if.cmd_valid_i = 1'b0;
    check("reset_out", 32'(out), 32'h00A5A5A5);
    check("reset_ready", 32'(cmd_if.cmd_ready_o), 32'd0);
    rst = 1'b0;
    tick();
    check("pass_latency", 32'(out), 32'h00123456);

    for (int i = 0; i < 4; i++) begin
      func = 24'($urandom);
      tick();
    end

    // Indefinite override of ch2 while func toggles.
    send(1, 2, 8'h3C, 0);
    check("held_val", 32'(out[23:16]), 32'h3C);
    for (int i = 0; i < 4; i++) begin
      func = 24'($urandom);
      tick();
      check("held_stays", 32'(out[23:16]), 32'h3C);
    end
    func[23:16] = 8'h00;
    send(2, 2, 8'h00, 0);
    check("release_val", 32'(out[23:16]), 32'h00);
    check("release_chg", 32'(chg[2]), 32'd1);

`ifdef OVR_TIMER_EN
    // Timed expiry after exactly five cycles.
    func[15:8] = 8'h12;
    send(1, 1, 8'hFF, 5);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("timed_hold", 32'(out[15:8]), 32'hFF);
    end
    tick();
    check("timed_release", 32'(out[15:8]), 32'h12);
    check("timed_expire", 32'(expo[1]), 32'd1);
    tick();
    check("expire_once", 32'(expo[1]), 32'd0);

    // Re-assign on the expiry edge wins over the expiry.
    send(1, 1, 8'h77, 3);
    tick();
    tick();
    send(1, 1, 8'h11, 4);
    check("reload_noexp", 32'(expo[1]), 32'd0);
    check("reload_val", 32'(out[15:8]), 32'h11);
    for (int i = 1; i < 4; i++) tick();
    tick();
    check("reload_expire", 32'(expo[1]), 32'd1);
`endif

    // Invalid channel: error pulse, no state change.
    send(1, 3, 8'h55, 0);
    check("err_pulse", 32'(err), 32'd1);
    check("err_nostate", 32'(act), 32'd0);
    tick();

    // Broadcast release of three held channels.
    send(1, 0, 8'hA1, 0);
    send(1, 1, 8'hB2, 0);
    send(1, 2, 8'hC3, 0);
    check("all_held", 32'(act), 32'h7);
    send(3, 3, 8'h00, 0);
    check("deassign_all", 32'(act), 32'h0);

`ifdef OVR_TIMER_EN
    // Reset lands with ten cycles of a timed override left.
    send(1, 0, 8'h09, 20);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_out", 32'(out), 32'h00A5A5A5);
    check("rst_mid_exp", 32'(expo), 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rst_mid_noexp", 32'(expo), 32'd0);
    end
`else
    // Without the timer, a nonzero hold still gives an indefinite override.
    send(1, 0, 8'h5A, 2);
    for (int i = 0; i < 110; i++) tick();
    check("notimer_held", 32'(act[0]), 32'd1);
    check("notimer_val", 32'(out[7:0]), 32'h5A);
    send(2, 0, 8'h00, 0);
`endif

    // Mixed random traffic against the scoreboard.
    for (int i = 0; i < 200; i++) begin
      func = 24'($urandom);
      if ($urandom_range(0, 2) == 0)
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             8'($urandom), int'($urandom_range(0, 6)));
      else
        tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
